wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - three-requester round-robin arbiter onto two register-file write ports (M, E)
module wb_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic [2:0] req_v,
  input  logic [2:0] req_dst0,
  input  logic [2:0] req_dst1,
  input  logic [2:0] req_dst2,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [7:0] req_data2,
  output logic [2:0] req_rdy,
  output logic [2:0] dstM,
  output logic [2:0] dstE,
  output logic [7:0] M,
  output logic [7:0] E,
  output logic [7:0] conflict_cnt
);

  logic [2:0] dst_a  [3];
  logic [7:0] data_a [3];

  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] dst_m_q, dst_m_d, dst_e_q, dst_e_d;
  logic [7:0] m_q, m_d, e_q, e_d;
  logic [7:0] cnt_q, cnt_d;

  logic [2:0] rdy_c;
  logic       m_v, e_v, conflict;
  logic [2:0] m_dst, e_dst;
  logic [7:0] m_data, e_data;
  logic [1:0] last_idx, idx;
  logic [2:0] sum;

  assign dst_a[0]  = req_dst0;
  assign dst_a[1]  = req_dst1;
  assign dst_a[2]  = req_dst2;
  assign data_a[0] = req_data0;
  assign data_a[1] = req_data1;
  assign data_a[2] = req_data2;

  // Scan from rr_ptr; dst 0 is a free accept, nonzero dst competes for M then E.
  always_comb begin
    rdy_c    = '0;
    m_v      = 1'b0;
    e_v      = 1'b0;
    m_dst    = '0;
    e_dst    = '0;
    m_data   = '0;
    e_data   = '0;
    last_idx = rr_ptr_q;
    conflict = 1'b0;
    idx      = '0;
    sum      = '0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, rr_ptr_q} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (req_v[idx]) begin
        if (dst_a[idx] == 3'd0) begin
          rdy_c[idx] = 1'b1;
        end else if (!m_v) begin
          m_v        = 1'b1;
          m_dst      = dst_a[idx];
          m_data     = data_a[idx];
          rdy_c[idx] = 1'b1;
          last_idx   = idx;
        end else if (!e_v) begin
          if (dst_a[idx] == m_dst) begin
            conflict = 1'b1;
          end else begin
            e_v        = 1'b1;
            e_dst      = dst_a[idx];
            e_data     = data_a[idx];
            rdy_c[idx] = 1'b1;
            last_idx   = idx;
          end
        end
      end
    end
    if (flush || !rst_n) rdy_c = '0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    dst_m_d  = '0;
    dst_e_d  = '0;
    m_d      = '0;
    e_d      = '0;
    if (!flush) begin
      dst_m_d = m_dst;
      m_d     = m_data;
      dst_e_d = e_dst;
      e_d     = e_data;
      if (m_v) rr_ptr_d = (last_idx == 2'd2) ? 2'd0 : last_idx + 2'd1;
      if (conflict && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      dst_m_q  <= '0;
      dst_e_q  <= '0;
      m_q      <= '0;
      e_q      <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      dst_m_q  <= dst_m_d;
      dst_e_q  <= dst_e_d;
      m_q      <= m_d;
      e_q      <= e_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_rdy      = rdy_c;
  assign dstM         = dst_m_q;
  assign dstE         = dst_e_q;
  assign M            = m_q;
  assign E            = e_q;
  assign conflict_cnt = cnt_q;

endmodule
